// File: rtl/board_ram_arbiter_pkg.sv
// Shared types for the board tile RAM arbiter: owner and clear-FSM encodings
// and the {y,x} address packing used across the tile-selection flow.
package board_ram_arbiter_pkg;

    localparam int X_WIDTH = 10;
    localparam int DEPTH   = 2 * X_WIDTH + 1;

    typedef logic [X_WIDTH:0] coord_t;
    typedef logic [DEPTH:0]   addr_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_H,
        OWN_C,
        OWN_S
    } owner_e;

    typedef enum logic [2:0] {
        CIDLE,
        CREQ,
        CRD,
        CWR,
        CDONE
    } clr_state_e;

    function automatic addr_t pack_addr(input coord_t y, input coord_t x);
        return {y, x};
    endfunction

endpackage

// File: rtl/board_ram_arbiter_mark_clear_sweeper.sv
// Mark-clear sweep engine: walks an inclusive rectangle row by row and
// read-modify-writes each tile through its requester port on the arbiter.
module mark_clear_sweeper
    import board_ram_arbiter_pkg::*;
#(
    parameter logic [3:0] CLEAR_MASK = 4'b1100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clean_mark,
    input  coord_t     box_x0,
    input  coord_t     box_y0,
    input  coord_t     box_x1,
    input  coord_t     box_y1,
    input  logic       win,
    input  logic [3:0] mem_rdata,
    output logic       clean_ready,
    output logic       req,
    output logic       we,
    output logic       boundary,
    output addr_t      addr,
    output logic [3:0] wdata
);

    clr_state_e state, state_n;
    coord_t     cx, cy, bx0, bx1, by1;
    logic       degen;
    logic       last;

    assign last        = (cx == bx1) && (cy == by1);
    assign clean_ready = (state == CIDLE);
    assign addr        = pack_addr(cy, cx);
    assign wdata       = mem_rdata & ~CLEAR_MASK;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= CIDLE;
        else       state <= state_n;
    end

    // NOTE: the box and cursor registers carry no reset; they are only read
    // after clean_mark has loaded them, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (state == CIDLE && clean_mark) begin
            bx0   <= box_x0;
            bx1   <= box_x1;
            by1   <= box_y1;
            cx    <= box_x0;
            cy    <= box_y0;
            degen <= (box_x1 < box_x0) || (box_y1 < box_y0);
        end else if (state == CWR && !last) begin
            if (cx == bx1) begin
                cx <= bx0;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        req      = 1'b0;
        we       = 1'b0;
        boundary = 1'b0;
        case (state)
            CIDLE: if (clean_mark) state_n = CREQ;
            CREQ: begin
                if (degen) begin
                    state_n = CDONE;
                end else begin
                    req = 1'b1;
                    if (win) state_n = CRD;
                end
            end
            CRD: begin
                req     = 1'b1;
                state_n = CWR;
            end
            CWR: begin
                req      = 1'b1;
                we       = 1'b1;
                boundary = 1'b1;
                if (last)     state_n = CDONE;
                else if (win) state_n = CRD;
                else          state_n = CREQ;
            end
            CDONE:   state_n = CIDLE;
            default: state_n = CIDLE;
        endcase
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Three-way arbiter for the single-port board tile RAM: host (H) > clear
// sweep (C) > search (S), with a burst limit and a 1-cycle ack per access.
module board_ram_arbiter
    import board_ram_arbiter_pkg::*;
#(
    parameter int         x_width    = X_WIDTH,
    parameter int         depth      = DEPTH,
    parameter int         BURST_MAX  = 16,
    parameter logic [3:0] CLEAR_MASK = 4'b1100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             h_req,
    input  logic             h_we,
    input  logic [depth:0]   h_addr,
    input  logic [3:0]       h_wdata,
    input  logic             s_req,
    input  logic             s_we,
    input  logic [depth:0]   s_addr,
    input  logic [3:0]       s_wdata,
    output logic             h_gnt,
    output logic             s_gnt,
    output logic             h_ack,
    output logic             s_ack,
    output logic [3:0]       rdata,
    input  logic             clean_mark,
    input  logic [x_width:0] box_x0,
    input  logic [x_width:0] box_y0,
    input  logic [x_width:0] box_x1,
    input  logic [x_width:0] box_y1,
    output logic             clean_ready,
    output logic [depth:0]   mem_addr,
    output logic             mem_we,
    output logic [3:0]       mem_wdata,
    input  logic [3:0]       mem_rdata
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    owner_e           owner, owner_n;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_n;
    logic             burst_hit, own_req, sel_we, rd_ack;
    logic [depth:0]   sel_addr, addr_q;
    logic [3:0]       sel_wdata, wdata_q, rdata_q;

    logic       c_req, c_we, c_boundary, c_win;
    addr_t      c_addr;
    logic [3:0] c_wdata;

    mark_clear_sweeper #(.CLEAR_MASK(CLEAR_MASK)) u_sweeper (
        .clk         (clk),
        .reset       (reset),
        .clean_mark  (clean_mark),
        .box_x0      (box_x0),
        .box_y0      (box_y0),
        .box_x1      (box_x1),
        .box_y1      (box_y1),
        .win         (c_win),
        .mem_rdata   (mem_rdata),
        .clean_ready (clean_ready),
        .req         (c_req),
        .we          (c_we),
        .boundary    (c_boundary),
        .addr        (c_addr),
        .wdata       (c_wdata)
    );

    assign h_gnt     = (owner == OWN_H);
    assign s_gnt     = (owner == OWN_S);
    assign c_win     = (owner_n == OWN_C);
    assign burst_hit = (burst_cnt >= CNT_W'(BURST_MAX - 1));

    always_comb begin
        own_req   = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = addr_q;
        sel_wdata = wdata_q;
        case (owner)
            OWN_H: begin own_req = h_req; sel_we = h_we; sel_addr = h_addr; sel_wdata = h_wdata; end
            OWN_C: begin own_req = c_req; sel_we = c_we; sel_addr = c_addr; sel_wdata = c_wdata; end
            OWN_S: begin own_req = s_req; sel_we = s_we; sel_addr = s_addr; sel_wdata = s_wdata; end
            default: ;
        endcase
    end

    // Idle cycles keep the last address and data on the RAM pins.
    assign mem_we    = own_req & sel_we;
    assign mem_addr  = own_req ? sel_addr : addr_q;
    assign mem_wdata = own_req ? sel_wdata : wdata_q;
    assign rdata     = rd_ack ? mem_rdata : rdata_q;

    // The sweep only yields between a write and its next read; a waiting
    // host always takes it there, others only once the burst is spent.
    always_comb begin
        owner_n = owner;
        case (owner)
            OWN_NONE: begin
                if (h_req)      owner_n = OWN_H;
                else if (c_req) owner_n = OWN_C;
                else if (s_req) owner_n = OWN_S;
            end
            OWN_H: if (!h_req || (burst_hit && (c_req || s_req))) owner_n = OWN_NONE;
            OWN_C: begin
                if (!c_req)
                    owner_n = OWN_NONE;
                else if (c_boundary && (h_req || (burst_hit && s_req)))
                    owner_n = OWN_NONE;
            end
            OWN_S: if (!s_req || (burst_hit && (h_req || c_req))) owner_n = OWN_NONE;
            default: owner_n = OWN_NONE;
        endcase

        if (owner_n != owner)        burst_cnt_n = '0;
        else if (own_req && !burst_hit) burst_cnt_n = burst_cnt + 1'b1;
        else                         burst_cnt_n = burst_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_NONE;
            burst_cnt <= '0;
            h_ack     <= 1'b0;
            s_ack     <= 1'b0;
            rd_ack    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            owner     <= owner_n;
            burst_cnt <= burst_cnt_n;
            h_ack     <= (owner == OWN_H) && h_req;
            s_ack     <= (owner == OWN_S) && s_req;
            rd_ack    <= own_req && !sel_we && (owner == OWN_H || owner == OWN_S);
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            if (rd_ack) rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter: a vector table for single accesses and
// priority, then hand sequences for burst limit, sweep, preemption and reset.
module tb_board_ram_arbiter;
    import board_ram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        h_req, h_we, s_req, s_we;
    addr_t       h_addr, s_addr;
    logic [3:0]  h_wdata, s_wdata;
    logic        h_gnt, s_gnt, h_ack, s_ack;
    logic [3:0]  rdata;
    logic        clean_mark;
    coord_t      box_x0, box_y0, box_x1, box_y1;
    logic        clean_ready;
    addr_t       mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    logic [3:0]  ram [addr_t];
    logic [25:0] we_log [$];

    board_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .h_gnt(h_gnt), .s_gnt(s_gnt), .h_ack(h_ack), .s_ack(s_ack),
        .rdata(rdata), .clean_mark(clean_mark),
        .box_x0(box_x0), .box_y0(box_y0), .box_x1(box_x1), .box_y1(box_y1),
        .clean_ready(clean_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ram_rd(input addr_t a);
        return ram.exists(a) ? ram[a] : 4'h0;
    endfunction

    // Behavioural RAM, 1-cycle read latency, read-before-write.
    always @(posedge clk) begin
        mem_rdata <= ram_rd(mem_addr);
        if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            we_log.push_back({mem_addr, mem_wdata});
        end
    end

    function automatic addr_t pa(input int y, input int x);
        return pack_addr(coord_t'(y), coord_t'(x));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_box(input int x0, input int y0, input int x1, input int y1);
        box_x0 = coord_t'(x0); box_y0 = coord_t'(y0);
        box_x1 = coord_t'(x1); box_y1 = coord_t'(y1);
    endtask

    typedef struct {
        logic       h_req, h_we;
        addr_t      h_addr;
        logic [3:0] h_wdata;
        logic       s_req;
        addr_t      s_addr;
        logic [1:0] e_gnt;   // {h,s}
        logic [1:0] e_ack;   // {h,s}
        logic       e_we;
        logic [3:0] e_rdata;
        addr_t      e_addr;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic hr, input logic hw, input addr_t ha, input logic [3:0] hd,
                       input logic sr, input addr_t sa, input logic [1:0] g, input logic [1:0] k,
                       input logic w, input logic [3:0] rd, input addr_t ea);
        vec_t v;
        v.h_req = hr; v.h_we = hw; v.h_addr = ha; v.h_wdata = hd;
        v.s_req = sr; v.s_addr = sa; v.e_gnt = g; v.e_ack = k;
        v.e_we = w; v.e_rdata = rd; v.e_addr = ea;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_t s1, ha, hb, hb2;
        int    busy, s_acks, h_acks, h_first, h_cnt;
        logic  exp_h, exp_s;
        logic [25:0] exp_log [$];

        s1 = pa(32, 33); ha = pa(3, 4); hb = pa(9, 9); hb2 = pa(7, 7);
        reset = 1'b1; h_req = 0; h_we = 0; h_addr = '0; h_wdata = 0;
        s_req = 0; s_we = 0; s_addr = '0; s_wdata = 0; clean_mark = 0;
        set_box(0, 0, 0, 0);
        ram[s1] = 4'h5; ram[ha] = 4'hA;
        step(); step();
        check("reset state", {clean_ready, h_gnt, s_gnt, h_ack, s_ack, mem_we, mem_addr, mem_wdata, rdata},
              {1'b1, 5'b0, 22'h0, 4'h0, 4'h0});
        reset = 1'b0;

        //   hreq hwe  haddr hd    sreq saddr  gnt    ack    we  rdata addr
        add(0, 0, '0, 4'h0, 1, s1, 2'b00, 2'b00, 0, 4'h0, '0);
        add(0, 0, '0, 4'h0, 1, s1, 2'b01, 2'b00, 0, 4'h0, s1);
        add(0, 0, '0, 4'h0, 0, s1, 2'b01, 2'b01, 0, 4'h5, s1);
        add(0, 0, '0, 4'h0, 0, s1, 2'b00, 2'b00, 0, 4'h5, s1);
        add(1, 1, ha, 4'h7, 1, s1, 2'b00, 2'b00, 0, 4'h5, s1);
        add(1, 1, ha, 4'h7, 1, s1, 2'b10, 2'b00, 1, 4'h5, ha);
        add(1, 0, ha, 4'h0, 1, s1, 2'b10, 2'b10, 0, 4'h5, ha);
        add(0, 0, ha, 4'h0, 1, s1, 2'b10, 2'b10, 0, 4'h7, ha);
        add(0, 0, ha, 4'h0, 1, s1, 2'b00, 2'b00, 0, 4'h7, ha);
        add(0, 0, ha, 4'h0, 1, s1, 2'b01, 2'b00, 0, 4'h7, s1);
        add(0, 0, ha, 4'h0, 0, s1, 2'b01, 2'b01, 0, 4'h5, s1);
        add(0, 0, ha, 4'h0, 0, s1, 2'b00, 2'b00, 0, 4'h5, s1);

        foreach (vecs[i]) begin
            h_req = vecs[i].h_req; h_we = vecs[i].h_we; h_addr = vecs[i].h_addr;
            h_wdata = vecs[i].h_wdata; s_req = vecs[i].s_req; s_addr = vecs[i].s_addr;
            #1;
            check($sformatf("vec%0d {gnt,ack,we,rdata,addr}", i),
                  {h_gnt, s_gnt, h_ack, s_ack, mem_we, rdata, mem_addr},
                  {vecs[i].e_gnt, vecs[i].e_ack, vecs[i].e_we, vecs[i].e_rdata, vecs[i].e_addr});
            step();
        end
        h_req = 0; s_req = 0; h_we = 0;
        step();

        // Burst limit: S streams reads, H asks from cycle 5 and leaves after 3 accesses.
        s_acks = 0; h_acks = 0;
        for (int c = 0; c < 44; c++) begin
            s_req = (c < 40); s_addr = s1;
            h_req = (c >= 5 && c <= 20); h_we = 1'b1; h_addr = hb; h_wdata = 4'h6;
            #1;
            exp_s = (c >= 1 && c <= 16) || (c >= 23 && c <= 40);
            exp_h = (c >= 18 && c <= 21);
            check($sformatf("burst c%0d {h_gnt,s_gnt}", c), {h_gnt, s_gnt}, {exp_h, exp_s});
            s_acks += int'(s_ack); h_acks += int'(h_ack);
            step();
        end
        h_req = 0; h_we = 0; s_req = 0;
        check("burst s_ack count", s_acks, 33);
        check("burst h_ack count", h_acks, 3);
        check("burst h write", ram_rd(hb), 4'h6);

        // Clear sweep of x 32..34, y 32..33 with a stray clean_mark while busy.
        for (int y = 31; y <= 34; y++)
            for (int x = 31; x <= 35; x++) ram[pa(y, x)] = 4'hF;
        we_log.delete();
        set_box(32, 32, 34, 33); clean_mark = 1'b1;
        #1;
        check("ready before sweep", clean_ready, 1'b1);
        step();
        clean_mark = 1'b0; busy = 0;
        while (!clean_ready && busy < 200) begin
            busy++;
            clean_mark = (busy == 3);
            if (busy == 3) set_box(100, 100, 100, 100);
            step();
        end
        clean_mark = 1'b0;
        check("sweep busy cycles", busy, 14);
        exp_log.delete();
        for (int y = 32; y <= 33; y++)
            for (int x = 32; x <= 34; x++) exp_log.push_back({pa(y, x), 4'h3});
        check("sweep write count", we_log.size(), 6);
        for (int i = 0; i < 6 && i < we_log.size(); i++)
            check($sformatf("sweep write %0d", i), we_log[i], exp_log[i]);
        check("sweep corner below box", ram_rd(pa(31, 32)), 4'hF);
        check("sweep right of box", ram_rd(pa(33, 35)), 4'hF);
        check("sweep left of box", ram_rd(pa(32, 31)), 4'hF);
        check("sweep above box", ram_rd(pa(34, 34)), 4'hF);

        // Host request during the first read of a sweep.
        for (int x = 10; x <= 12; x++) ram[pa(5, x)] = 4'hE;
        ram[hb2] = 4'h0;
        we_log.delete();
        set_box(10, 5, 12, 5); clean_mark = 1'b1;
        step();
        clean_mark = 1'b0;
        step();
        h_first = -1; h_cnt = 0;
        h_we = 1'b1; h_addr = hb2; h_wdata = 4'h9;
        for (int r = 2; r < 20; r++) begin
            h_req = (r <= 5);
            #1;
            if (h_gnt) begin
                h_cnt++;
                if (h_first < 0) h_first = r;
            end
            step();
        end
        h_req = 0; h_we = 0;
        check("preempt h_gnt first cycle", h_first, 5);
        check("preempt h_gnt cycles", h_cnt, 2);
        check("preempt ready after", clean_ready, 1'b1);
        exp_log.delete();
        exp_log.push_back({pa(5, 10), 4'h2});
        exp_log.push_back({hb2, 4'h9});
        exp_log.push_back({pa(5, 11), 4'h2});
        exp_log.push_back({pa(5, 12), 4'h2});
        check("preempt write count", we_log.size(), 4);
        for (int i = 0; i < 4 && i < we_log.size(); i++)
            check($sformatf("preempt write %0d", i), we_log[i], exp_log[i]);

        // Reset mid-sweep, then a degenerate box.
        for (int x = 0; x <= 5; x++) ram[pa(0, x)] = 4'hF;
        set_box(0, 0, 20, 0); clean_mark = 1'b1;
        step();
        clean_mark = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("reset mid-sweep {ready,h_gnt,s_gnt}", {clean_ready, h_gnt, s_gnt}, 3'b100);
        check("reset cell0 cleared", ram_rd(pa(0, 0)), 4'h3);
        check("reset cell1 untouched", ram_rd(pa(0, 1)), 4'hF);
        we_log.delete();
        set_box(5, 0, 3, 0); clean_mark = 1'b1;
        step();
        clean_mark = 1'b0; busy = 0;
        while (!clean_ready && busy < 50) begin
            busy++;
            step();
        end
        check("degenerate busy cycles", busy, 2);
        check("degenerate writes", we_log.size(), 0);

        set_box(4, 0, 4, 9); clean_mark = 1'b1;
        step();
        clean_mark = 1'b0;
        step(); step();
        we_log.delete();
        set_box(6, 6, 6, 2); clean_mark = 1'b1;
        #1;
        check("mark ignored while busy", clean_ready, 1'b0);
        step();
        clean_mark = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
